// File: rtl/gate_pkg.sv
// Shared types and limits for the registered multi-input gate unit.
package gate_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NAND = 3'd2,
        OP_NOR  = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_PASS = 3'd6,
        OP_RSVD = 3'd7
    } gate_op_e;

    localparam int MAX_NUM_IN = 8;

endpackage

// File: rtl/gate_reduce.sv
// Combinational per-lane reduction of NUM_IN operands under a selectable gate function.
module gate_reduce
    import gate_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2
) (
    input  logic [NUM_IN*WIDTH-1:0] operands,
    input  gate_op_e                op,
    output logic [WIDTH-1:0]        result,
    output logic                    err
);

    logic [WIDTH-1:0] and_r;
    logic [WIDTH-1:0] or_r;
    logic [WIDTH-1:0] xor_r;

    always_comb begin
        and_r = operands[WIDTH-1:0];
        or_r  = operands[WIDTH-1:0];
        xor_r = operands[WIDTH-1:0];
        for (int k = 1; k < NUM_IN; k++) begin
            and_r = and_r & operands[k*WIDTH +: WIDTH];
            or_r  = or_r  | operands[k*WIDTH +: WIDTH];
            xor_r = xor_r ^ operands[k*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        result = '0;
        err    = 1'b0;
        case (op)
            OP_AND:  result = and_r;
            OP_OR:   result = or_r;
            OP_NAND: result = ~and_r;
            OP_NOR:  result = ~or_r;
            OP_XOR:  result = xor_r;
            OP_XNOR: result = ~xor_r;
            OP_PASS: result = operands[WIDTH-1:0];
            default: err    = 1'b1;
        endcase
    end

endmodule

// File: rtl/logic_gate_pipe.sv
// Registered gate unit: one-cycle latency, main output register backed by a one-entry skid
// register so in_ready can be a flop, plus a saturating count of delivered beats.
module logic_gate_pipe
    import gate_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [2:0]              in_op,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_err,
    output logic [CNT_W-1:0]        beat_cnt
);

    if (NUM_IN < 2 || NUM_IN > MAX_NUM_IN) begin : g_num_in_check
        $error("logic_gate_pipe: NUM_IN=%0d outside 2..%0d", NUM_IN, MAX_NUM_IN);
    end

    logic [WIDTH-1:0] res;
    logic             res_err;

    gate_reduce #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) u_reduce (
        .operands (in_data),
        .op       (gate_op_e'(in_op)),
        .result   (res),
        .err      (res_err)
    );

    logic             main_valid_q, main_valid_d;
    logic [WIDTH-1:0] main_data_q,  main_data_d;
    logic             main_err_q,   main_err_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q,  skid_data_d;
    logic             skid_err_q,   skid_err_d;
    logic             in_ready_q,   in_ready_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic             in_fire;
    logic             out_fire;

    always_comb begin
        in_fire      = in_valid & in_ready_q;
        out_fire     = main_valid_q & out_ready;
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_err_d   = main_err_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_err_d   = skid_err_q;
        cnt_d        = cnt_q;

        if (out_fire) begin
            if (skid_valid_q) begin
                main_data_d  = skid_data_q;
                main_err_d   = skid_err_q;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = 1'b0;
            end
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // in_fire implies skid is empty, so a draining main can always take the new beat.
        if (in_fire) begin
            if (!main_valid_q || out_fire) begin
                main_valid_d = 1'b1;
                main_data_d  = res;
                main_err_d   = res_err;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = res;
                skid_err_d   = res_err;
            end
        end

        in_ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_err_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_err_q   <= 1'b0;
            in_ready_q   <= 1'b1;
            cnt_q        <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_err_q   <= main_err_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_err_q   <= skid_err_d;
            in_ready_q   <= in_ready_d;
            cnt_q        <= cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign out_err   = main_err_q;
    assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Scoreboard bench for logic_gate_pipe: three instances cover 1-bit NOR, 3-operand byte
// lanes with backpressure/reset, and a 2-bit saturating beat counter.
module tb_logic_gate_pipe;
    import gate_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // 1-bit, 2-input instance
    logic        nor_rst, nor_in_valid, nor_in_ready, nor_out_valid, nor_out_ready, nor_out_err;
    logic [1:0]  nor_in_data;
    logic [2:0]  nor_in_op;
    logic [0:0]  nor_out_data;
    logic [15:0] nor_beat_cnt;

    logic_gate_pipe #(.WIDTH(1), .NUM_IN(2), .CNT_W(16)) u_nor (
        .clk(clk), .rst(nor_rst), .in_valid(nor_in_valid), .in_ready(nor_in_ready),
        .in_data(nor_in_data), .in_op(nor_in_op), .out_valid(nor_out_valid),
        .out_ready(nor_out_ready), .out_data(nor_out_data), .out_err(nor_out_err),
        .beat_cnt(nor_beat_cnt)
    );

    // 8-bit, 3-input instance
    logic        gw_rst, gw_in_valid, gw_in_ready, gw_out_valid, gw_out_ready, gw_out_err;
    logic [23:0] gw_in_data;
    logic [2:0]  gw_in_op;
    logic [7:0]  gw_out_data;
    logic [15:0] gw_beat_cnt;

    logic_gate_pipe #(.WIDTH(8), .NUM_IN(3), .CNT_W(16)) u_gw (
        .clk(clk), .rst(gw_rst), .in_valid(gw_in_valid), .in_ready(gw_in_ready),
        .in_data(gw_in_data), .in_op(gw_in_op), .out_valid(gw_out_valid),
        .out_ready(gw_out_ready), .out_data(gw_out_data), .out_err(gw_out_err),
        .beat_cnt(gw_beat_cnt)
    );

    // 2-bit counter instance
    logic        sat_rst, sat_in_valid, sat_in_ready, sat_out_valid, sat_out_ready, sat_out_err;
    logic [15:0] sat_in_data;
    logic [2:0]  sat_in_op;
    logic [7:0]  sat_out_data;
    logic [1:0]  sat_beat_cnt;

    logic_gate_pipe #(.WIDTH(8), .NUM_IN(2), .CNT_W(2)) u_sat (
        .clk(clk), .rst(sat_rst), .in_valid(sat_in_valid), .in_ready(sat_in_ready),
        .in_data(sat_in_data), .in_op(sat_in_op), .out_valid(sat_out_valid),
        .out_ready(sat_out_ready), .out_data(sat_out_data), .out_err(sat_out_err),
        .beat_cnt(sat_beat_cnt)
    );

    logic [1:0] nor_pat [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    int         nor_exp [4] = '{1, 0, 0, 0};
    int         sat_exp [5] = '{1, 2, 3, 3, 3};
    logic [7:0] t2_exp  [7] = '{8'h80, 8'hFE, 8'h7F, 8'h01, 8'h96, 8'h69, 8'hF0};

    logic [8:0] sb [$];
    int         n_sent = 0;

    // {err, data} for three byte operands; op 7 gives zero data with err set
    function automatic logic [8:0] model(input logic [23:0] d, input logic [2:0] op);
        logic [7:0] a, b, c;
        a = d[7:0];
        b = d[15:8];
        c = d[23:16];
        case (op)
            3'd0: return {1'b0, a & b & c};
            3'd1: return {1'b0, a | b | c};
            3'd2: return {1'b0, ~(a & b & c)};
            3'd3: return {1'b0, ~(a | b | c)};
            3'd4: return {1'b0, a ^ b ^ c};
            3'd5: return {1'b0, ~(a ^ b ^ c)};
            3'd6: return {1'b0, a};
            default: return {1'b1, 8'h00};
        endcase
    endfunction

    // Called at posedge+1; returns at posedge+1 right after the beat is accepted.
    task automatic send(input logic [23:0] d, input logic [2:0] op, input logic [8:0] exp);
        int n;
        n = 0;
        gw_in_valid = 1'b1;
        gw_in_data  = d;
        gw_in_op    = op;
        @(negedge clk);
        while (!gw_in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("send_accept", 32'(gw_in_ready), 1);
        sb.push_back(exp);
        n_sent++;
        @(posedge clk);
        #1;
        gw_in_valid = 1'b0;
        gw_in_data  = 24'($urandom);
        gw_in_op    = 3'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_left", 32'(sb.size()), 0);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Output monitor: pops the scoreboard on each transfer, checks hold stability on stalls.
    initial begin
        logic [9:0] got;
        logic [9:0] held_val;
        logic       held;
        held     = 1'b0;
        held_val = '0;
        forever begin
            @(negedge clk);
            got = {gw_out_valid, gw_out_err, gw_out_data};
            if (gw_rst) begin
                held = 1'b0;
            end else begin
                if (held) check("gw_stable", 32'(got), 32'(held_val));
                held     = gw_out_valid && !gw_out_ready;
                held_val = got;
                if (gw_out_valid && gw_out_ready) begin
                    if (sb.size() == 0) check("gw_extra_beat", 1, 0);
                    else check("gw_sb", 32'(got[8:0]), 32'(sb.pop_front()));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nor_rst = 1'b1; gw_rst = 1'b1; sat_rst = 1'b1;
        nor_in_valid = 1'b0; gw_in_valid = 1'b0; sat_in_valid = 1'b0;
        nor_out_ready = 1'b1; gw_out_ready = 1'b1; sat_out_ready = 1'b1;
        nor_in_data = '0; gw_in_data = '0; sat_in_data = '0;
        nor_in_op = '0; gw_in_op = '0; sat_in_op = '0;
        repeat (2) @(posedge clk);
        #1;
        nor_rst = 1'b0; gw_rst = 1'b0; sat_rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(gw_out_valid), 0);
        check("rst_out_data",  32'(gw_out_data), 0);
        check("rst_out_err",   32'(gw_out_err), 0);
        check("rst_beat_cnt",  32'(gw_beat_cnt), 0);
        check("rst_in_ready",  32'(gw_in_ready), 1);
        check("rst_nor_ready", 32'(nor_in_ready), 1);

        // T1: 1-bit NOR truth table back-to-back
        for (int i = 0; i < 4; i++) begin
            nor_in_valid = 1'b1;
            nor_in_data  = nor_pat[i];
            nor_in_op    = OP_NOR;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("t1_valid%0d", i), 32'(nor_out_valid), 1);
            check($sformatf("t1_data%0d", i), 32'(nor_out_data), nor_exp[i]);
        end
        nor_in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t1_beat_cnt", 32'(nor_beat_cnt), 4);
        check("t1_idle", 32'(nor_out_valid), 0);

        // T5: 2-bit counter saturates
        for (int i = 0; i < 5; i++) begin
            sat_in_valid = 1'b1;
            sat_in_data  = 16'($urandom);
            sat_in_op    = 3'($urandom_range(0, 6));
            @(posedge clk);
            @(negedge clk);
            if (i > 0) check($sformatf("t5_cnt%0d", i), 32'(sat_beat_cnt), sat_exp[i-1]);
        end
        sat_in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t5_cnt_final", 32'(sat_beat_cnt), sat_exp[4]);

        // T2 and T3: all ops on fixed operands, then reserved op
        @(posedge clk);
        #1;
        for (int i = 0; i < 7; i++) send(24'hAACCF0, 3'(i), {1'b0, t2_exp[i]});
        for (int i = 0; i < 2; i++) send(24'($urandom), 3'd7, {1'b1, 8'h00});
        drain();
        check("t3_beat_cnt", 32'(gw_beat_cnt), n_sent);

        // T4: five-beat stream with a three-cycle stall
        @(posedge clk);
        #1;
        fork
            begin : t4_drive
                logic [23:0] d;
                logic [2:0]  op;
                for (int i = 0; i < 5; i++) begin
                    d  = 24'($urandom);
                    op = 3'($urandom_range(0, 6));
                    send(d, op, model(d, op));
                end
            end
            begin : t4_stall
                repeat (2) @(posedge clk);
                #1;
                gw_out_ready = 1'b0;
                @(negedge clk);
                @(negedge clk);
                check("t4_in_ready_low", 32'(gw_in_ready), 0);
                repeat (2) @(posedge clk);
                #1;
                gw_out_ready = 1'b1;
            end
        join
        drain();
        check("t4_beat_cnt", 32'(gw_beat_cnt), n_sent);

        // T6: reset with main and skid both occupied
        @(posedge clk);
        #1;
        gw_out_ready = 1'b0;
        send(24'h123456, 3'd4, model(24'h123456, 3'd4));
        send(24'h0F0F0F, 3'd1, model(24'h0F0F0F, 3'd1));
        @(negedge clk);
        check("t6_full_ready", 32'(gw_in_ready), 0);
        check("t6_full_valid", 32'(gw_out_valid), 1);
        @(posedge clk);
        #1;
        gw_rst = 1'b1;
        @(posedge clk);
        #1;
        gw_rst = 1'b0;
        sb.delete();
        n_sent = 0;
        gw_out_ready = 1'b1;
        @(negedge clk);
        check("t6_out_valid", 32'(gw_out_valid), 0);
        check("t6_beat_cnt",  32'(gw_beat_cnt), 0);
        check("t6_in_ready",  32'(gw_in_ready), 1);
        gw_in_valid = 1'b1;
        gw_in_data  = 24'h00FF3C;
        gw_in_op    = 3'd6;
        sb.push_back(model(24'h00FF3C, 3'd6));
        n_sent++;
        @(posedge clk);
        #1;
        gw_in_valid = 1'b0;
        @(negedge clk);
        check("t6_lat_valid", 32'(gw_out_valid), 1);
        check("t6_lat_data",  32'(gw_out_data), 32'h3C);
        drain();
        check("t6_beat_cnt_after", 32'(gw_beat_cnt), n_sent);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
